// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with NZVC flags and an architectural flag register.
// Latency: 2 cycles from input accept to out_valid; throughput 1 beat/cycle.
// Backpressure: valid/ready; in_ready drops only when both stages hold beats and out_ready is low.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [3:0]       flags
);

  // Stage 1: captured operands
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_cntrl_q;
  logic             s1_sf_q;

  // Stage 2: computed result and flags
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  logic             s2_n_q, s2_z_q, s2_v_q, s2_c_q;
  logic             s2_sf_q;

  logic [3:0]       flags_q;

  // Next-state values for stage 2
  logic [WIDTH-1:0] res_d;
  logic             n_d, z_d, v_d, c_d;

  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             is_arith;
  logic [WIDTH:0]   sum_w;

  logic s2_adv;
  logic accept;
  logic retire;

  // S2 may take a beat if it is empty or its beat is leaving this cycle
  assign s2_adv    = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_adv;
  assign accept    = in_valid && in_ready;
  assign retire    = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign negative  = s2_n_q;
  assign zero      = s2_z_q;
  assign overflow  = s2_v_q;
  assign carry_out = s2_c_q;
  assign flags     = flags_q;

  // Operation decode and flag generation from stage-1 contents
  always_comb begin
    op_b     = s1_b_q;
    cin      = 1'b0;
    is_arith = 1'b0;
    res_d    = '0;
    c_d      = 1'b0;
    v_d      = 1'b0;
    case (s1_cntrl_q)
      3'b000: res_d = s1_b_q;
      3'b010: is_arith = 1'b1;
      3'b011: begin
        op_b     = ~s1_b_q;
        cin      = 1'b1;
        is_arith = 1'b1;
      end
      3'b100: res_d = s1_a_q & s1_b_q;
      3'b101: res_d = s1_a_q | s1_b_q;
      3'b110: res_d = s1_a_q ^ s1_b_q;
      default: res_d = '0;
    endcase
    // Subtract reuses the adder as A + ~B + 1
    sum_w = {1'b0, s1_a_q} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    if (is_arith) begin
      res_d = sum_w[WIDTH-1:0];
      c_d   = sum_w[WIDTH];
      v_d   = (s1_a_q[WIDTH-1] == op_b[WIDTH-1]) && (res_d[WIDTH-1] != s1_a_q[WIDTH-1]);
    end
    n_d = res_d[WIDTH-1];
    z_d = (res_d == '0);
  end

  // Stage 1 capture; slot frees when its beat moves on to S2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cntrl_q <= 3'b000;
      s1_sf_q    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= a;
        s1_b_q     <= b;
        s1_cntrl_q <= cntrl;
        s1_sf_q    <= set_flags;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Stage 2 capture; data holds on drain so result keeps its last value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_n_q     <= 1'b0;
      s2_z_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_c_q     <= 1'b0;
      s2_sf_q    <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= 1'b1;
        s2_res_q   <= res_d;
        s2_n_q     <= n_d;
        s2_z_q     <= z_d;
        s2_v_q     <= v_d;
        s2_c_q     <= c_d;
        s2_sf_q    <= s1_sf_q;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  // Architectural flags commit only when a flag-setting beat retires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (retire && s2_sf_q) begin
      flags_q <= {s2_n_q, s2_z_q, s2_v_q, s2_c_q};
    end
  end

endmodule
